// File: rtl/shift_register_rx.sv
// Serial frame receiver: start, WIDTH data bits LSB first, optional parity, stop.
// Define SHIFT_REGISTER_RX_PARITY_EN to add an even-parity bit after the data.
module shift_register_rx #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             SIn,
  input  logic             Ack,
  output logic [WIDTH-1:0] D,
  output logic             Valid,
  output logic             Overrun,
  output logic             FrameErr,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SHIFT_REGISTER_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd3
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             perr;

`ifdef SHIFT_REGISTER_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!SIn) state_d = DATA;
      DATA: begin
        if (cnt_q == LAST) begin
`ifdef SHIFT_REGISTER_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SHIFT_REGISTER_RX_PARITY_EN
      PARITY: state_d = STOP;
`endif
      STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    d_d     = d_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
`ifdef SHIFT_REGISTER_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (Ack) valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (!SIn) cnt_d = '0;
      DATA: begin
        sr_d  = {SIn, sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
`ifdef SHIFT_REGISTER_RX_PARITY_EN
      PARITY: perr_d = (^sr_q) ^ SIn;
`endif
      STOP: begin
        // A good word wins over a same-edge Ack, so Valid stays high
        if (SIn && !perr) begin
          d_d     = sr_q;
          valid_d = 1'b1;
          if (valid_q && !Ack) ovr_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SHIFT_REGISTER_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
`ifdef SHIFT_REGISTER_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    Busy     = (state_q != IDLE);
    D        = d_q;
    Valid    = valid_q;
    Overrun  = ovr_q;
    FrameErr = ferr_q;
  end

endmodule
